gpu_axi_sram_slave: RTL
=======================

# gpu_axi_sram_slave

AXI slave memory that terminates the GPU subsystem's 64-bit AXI master port directly downstream of it. It accepts write and read bursts and stores data in an internal byte-strobed word array. Out-of-range or unsupported accesses get SLVERR responses. Read and write paths are independent state machines, one outstanding transaction each, and can run concurrently.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width (fixed 64; strobe width DATA_W/8)
- ID_W, 8, read ID width
- DEPTH, 1024, array depth in 64-bit words (power of two)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*8 aligned)

Ports:
- acr_clk  in  1  sole clock, rising edge
- acr_rst  in  1  reset, asynchronous assert, active-low
- axi_awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  32/4/3/2/1/4/3  write address; lock/cache/prot accepted and ignored
- axi_awvalid in 1, axi_awready out 1
- axi_wdata in 64, axi_wstrb in 8, axi_wlast in 1, axi_wvalid in 1, axi_wready out 1
- axi_bid out 8 (constant 0, the write channel carries no ID), axi_bresp out 2, axi_bvalid out 1, axi_bready in 1
- axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  8/32/4/3/2/1/4/3  read address
- axi_arvalid in 1, axi_arready out 1
- axi_rid out 8, axi_rdata out 64, axi_rresp out 2, axi_rlast out 1, axi_rvalid out 1, axi_rready in 1

## Operation
- Write FSM states:
  - W_IDLE: awready=1. On AW handshake, latch addr, len, size and burst; clear the error flag; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes bytes selected by wstrb to word (addr-BASE_ADDR)>>3, unless that beat errors. On the beat with count==len, go to W_RESP. wlast is ignored; the beat count is authoritative.
  - W_RESP: bvalid=1, bresp=SLVERR if any beat errored, else OKAY. On bready, return to W_IDLE.
- Read FSM states:
  - R_IDLE: arready=1. On AR handshake, latch rid and burst parameters, then load the beat-0 word into the rdata register; go to R_DATA.
  - R_DATA: rvalid=1. rlast=(count==len). rresp is per beat. On a non-last handshake, load the next word. On the last handshake, return to R_IDLE.
- Beat addressing:
  - INCR: addr += (1<<size) per beat, wrapping mod 2^32.
  - FIXED: addr is unchanged.
  - WRAP (2'b10) and reserved (2'b11): every beat errors.
- A beat errors if size>3, the burst type is unsupported, or the address is outside [BASE_ADDR, BASE_ADDR+DEPTH*8).
- Errored beats:
  - Writes: the array is untouched.
  - Reads: rdata=0, rresp=SLVERR.
- Narrow transfers: reads return the full 64-bit word; writes rely on wstrb alone.
- Exclusive access (awlock/arlock=1) is treated as normal and returns OKAY, never EXOKAY.
- Same-cycle write and read to the same word: the read-register load takes the pre-write value.
- Array contents are not reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. bid is always 0.
- The first cycle after acr_rst deasserts: awready=1 and arready=1. All outputs are registered.
- Write: wready rises 1 cycle after the AW handshake. bvalid rises 1 cycle after the final W handshake. awready rises 1 cycle after the B handshake.
- Read: rvalid rises 1 cycle after the AR handshake. Back-to-back beats run at 1 per cycle while rready=1.
- While rvalid=1 and rready=0, rdata, rresp, rlast and rid hold stable. bvalid/bresp hold until bready.
- Reset asserted mid-burst: both FSMs return to IDLE immediately. Partially written words stay written.

## Structure
- Package gpu_axi_pkg holds:
  - burst constants (FIXED=0, INCR=1, WRAP=2)
  - response constants (OKAY=0, SLVERR=2)
  - write and read state enums
  - the next-address function (addr, size, burst)
- Sub-module gpu_axi_sram_array: DEPTH x 64 register array with one write port (word index, data, 8-bit byte enable) and one combinational read port. The slave holds the rdata register.

## Test plan
- Reset release → awready=arready=1 on the first cycle; all valids 0.
- INCR write at 0x100, len=3, size=3, data 0x11..0x44, full strobes → bresp=OKAY. Then INCR read at 0x100, len=3, arid=0x5A → rdata 0x11,0x22,0x33,0x44; rid=0x5A; rlast on beat 3 only.
- Write at 0x8, wstrb=8'h0F, data 0xFFFF_FFFF_AAAA_BBBB over stored 0 → read returns 0x0000_0000_AAAA_BBBB.
- INCR read len=1 starting at the last in-range word (BASE_ADDR+DEPTH*8-8) → beat 0 OKAY, beat 1 SLVERR with rdata 0.
- Write to an out-of-range address → bresp=SLVERR and array unchanged on readback. WRAP burst of len 3 → 4 beats accepted, bresp=SLVERR.
- Read with rready toggled 1-0-0-1 → rdata stable across stalls. Concurrently run an independent write burst → both complete correctly. Assert acr_rst mid-read → rvalid drops immediately.

Source files
------------

// File: rtl/gpu_axi_pkg.sv
// Shared constants, FSM state types and beat-address helper for the GPU AXI SRAM slave.
package gpu_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // FIXED and the error-only burst types leave the address alone.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_INCR) return addr + (32'd1 << size);
    return addr;
  endfunction

endpackage

// File: rtl/gpu_axi_sram_array.sv
// Word array with one byte-enabled write port and one combinational read port.
module gpu_axi_sram_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       widx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic [AW-1:0]       ridx,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (wbe[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/gpu_axi_sram_slave.sv
// AXI slave SRAM terminating the GPU master port; independent read/write FSMs,
// one outstanding burst each. Bad beats (size, burst type, range) answer SLVERR.
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting beats until count == len
//   W_RESP | bvalid high, holding bresp until bready
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high, presenting the rdata register
module gpu_axi_sram_slave
  import gpu_axi_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 8,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                acr_clk,
  input  logic                acr_rst,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [3:0]          axi_awlen,
  input  logic [2:0]          axi_awsize,
  input  logic [1:0]          axi_awburst,
  input  logic                axi_awlock,
  input  logic [3:0]          axi_awcache,
  input  logic [2:0]          axi_awprot,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  input  logic                axi_wlast,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  output logic [ID_W-1:0]     axi_bid,
  output logic [1:0]          axi_bresp,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  input  logic [ID_W-1:0]     axi_arid,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [3:0]          axi_arlen,
  input  logic [2:0]          axi_arsize,
  input  logic [1:0]          axi_arburst,
  input  logic                axi_arlock,
  input  logic [3:0]          axi_arcache,
  input  logic [2:0]          axi_arprot,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [ID_W-1:0]     axi_rid,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic                axi_rvalid,
  input  logic                axi_rready
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * 8);

  w_state_e          w_state, w_next;
  r_state_e          r_state, r_next;
  logic [ADDR_W-1:0] aw_addr, r_addr, rd_addr, wr_off, rd_off;
  logic [3:0]        aw_len, w_cnt, r_len, r_cnt;
  logic [2:0]        aw_size, r_size, rd_size;
  logic [1:0]        aw_burst, r_burst, rd_burst;
  logic              w_err, wr_err, rd_err, wr_en;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_ok;

  assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot, axi_wlast,
                       axi_arlock, axi_arcache, axi_arprot};
  assign axi_bid   = '0;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid  && axi_wready;
  assign b_hs  = axi_bvalid  && axi_bready;
  assign ar_hs = axi_arvalid && axi_arready;
  assign r_hs  = axi_rvalid  && axi_rready;

  assign wr_off = aw_addr - BASE_ADDR;
  assign wr_err = (aw_size > 3'd3) || !(aw_burst == BURST_FIXED || aw_burst == BURST_INCR)
                  || ({1'b0, wr_off} >= SPAN);
  assign wr_en  = w_hs && !wr_err;

  // Idle looks at the incoming AR so beat 0 loads on the handshake edge.
  assign rd_addr  = (r_state == R_IDLE) ? axi_araddr  : r_addr;
  assign rd_size  = (r_state == R_IDLE) ? axi_arsize  : r_size;
  assign rd_burst = (r_state == R_IDLE) ? axi_arburst : r_burst;
  assign rd_off   = rd_addr - BASE_ADDR;
  assign rd_err   = (rd_size > 3'd3) || !(rd_burst == BURST_FIXED || rd_burst == BURST_INCR)
                    || ({1'b0, rd_off} >= SPAN);

  gpu_axi_sram_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_array (
    .clk   (acr_clk),
    .we    (wr_en),
    .widx  (wr_off[AW+2:3]),
    .wdata (axi_wdata),
    .wbe   (axi_wstrb),
    .ridx  (rd_off[AW+2:3]),
    .rdata (mem_rdata)
  );

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_cnt == aw_len) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge acr_clk or negedge acr_rst) begin
    if (!acr_rst) begin
      w_state     <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      aw_addr     <= '0;
      aw_len      <= '0;
      aw_size     <= '0;
      aw_burst    <= '0;
      w_cnt       <= '0;
      w_err       <= 1'b0;
    end else begin
      w_state     <= w_next;
      axi_awready <= (w_next == W_IDLE);
      axi_wready  <= (w_next == W_DATA);
      axi_bvalid  <= (w_next == W_RESP);
      if (aw_hs) begin
        aw_addr  <= axi_awaddr;
        aw_len   <= axi_awlen;
        aw_size  <= axi_awsize;
        aw_burst <= axi_awburst;
        w_cnt    <= '0;
        w_err    <= 1'b0;
      end
      if (w_hs) begin
        aw_addr <= next_addr(aw_addr, aw_size, aw_burst);
        w_cnt   <= w_cnt + 4'd1;
        w_err   <= w_err || wr_err;
        if (w_cnt == aw_len) axi_bresp <= (w_err || wr_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && r_cnt == r_len) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge acr_clk or negedge acr_rst) begin
    if (!acr_rst) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rlast   <= 1'b0;
      axi_rresp   <= RESP_OKAY;
      axi_rid     <= '0;
      axi_rdata   <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= r_next;
      axi_arready <= (r_next == R_IDLE);
      axi_rvalid  <= (r_next == R_DATA);
      if (ar_hs) begin
        axi_rid   <= axi_arid;
        r_len     <= axi_arlen;
        r_size    <= axi_arsize;
        r_burst   <= axi_arburst;
        r_cnt     <= '0;
        r_addr    <= next_addr(axi_araddr, axi_arsize, axi_arburst);
        axi_rlast <= (axi_arlen == 4'd0);
        axi_rdata <= rd_err ? '0 : mem_rdata;
        axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs) begin
        if (r_cnt == r_len) begin
          axi_rlast <= 1'b0;
        end else begin
          r_addr    <= next_addr(r_addr, r_size, r_burst);
          r_cnt     <= r_cnt + 4'd1;
          axi_rlast <= ((r_cnt + 4'd1) == r_len);
          axi_rdata <= rd_err ? '0 : mem_rdata;
          axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

endmodule
